// File: rtl/pc_sequencer.sv
// PC and run-state sequencer: IDLE/RUN/DONE, branch target LUT, stall/halt.
// Optional PC_SEQ_CYCLE_CNT_EN adds a saturating RUN cycle counter.
module pc_sequencer #(
  parameter int unsigned PC_W       = 10,
  parameter int unsigned START_ADDR = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req,
  output logic            done,
  output logic            fetch_en,
  output logic [PC_W-1:0] prog_addr,
  input  logic            branch,
  input  logic [1:0]      how_high,
  input  logic            take,
  input  logic            halt,
  input  logic            stall,
  input  logic            lut_we,
  input  logic [1:0]      lut_addr,
  input  logic [PC_W-1:0] lut_data
`ifdef PC_SEQ_CYCLE_CNT_EN
  ,
  output logic [31:0]     cycle_cnt
`endif
);

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] lut_q [4];
  logic            lut_wr;

  assign lut_wr = (state_q == S_IDLE) && lut_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) lut_q[i] <= '0;
    end else if (lut_wr) begin
      lut_q[lut_addr] <= lut_data;
    end
  end

  // Priority in RUN: stall > halt > taken branch > increment
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_RUN;
          pc_d    = START_PC;
        end
      end
      S_RUN: begin
        if (stall) begin
          pc_d = pc_q;
        end else if (halt) begin
          state_d = S_DONE;
        end else if (branch && take) begin
          pc_d = lut_q[how_high];
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      S_DONE: begin
        if (!req) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign done      = (state_q == S_DONE);
  assign fetch_en  = (state_q == S_RUN);
  assign prog_addr = pc_q;

`ifdef PC_SEQ_CYCLE_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_IDLE && req) begin
      cnt_d = '0;
    end else if (state_q == S_RUN && cnt_q != '1) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cycle_cnt = cnt_q;
`else
  // Counter absent in this build
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: two instances (PC_W=10/start 0 and
// PC_W=4/start 14) driven in lockstep against a behavioural model.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       reset, req, branch, take, halt, stall, lut_we;
  logic [1:0] how_high, lut_addr;
  logic [9:0] lut_data;

  logic       done_a, fe_a, done_b, fe_b;
  logic [9:0] addr_a;
  logic [3:0] addr_b;
`ifdef PC_SEQ_CYCLE_CNT_EN
  logic [31:0] cnt_a, cnt_b;
`endif

  always #5 clk = ~clk;

  pc_sequencer #(.PC_W(10), .START_ADDR(0)) u_a (
    .clk(clk), .reset(reset), .req(req), .done(done_a),
    .fetch_en(fe_a), .prog_addr(addr_a), .branch(branch),
    .how_high(how_high), .take(take), .halt(halt), .stall(stall),
    .lut_we(lut_we), .lut_addr(lut_addr), .lut_data(lut_data)
`ifdef PC_SEQ_CYCLE_CNT_EN
    , .cycle_cnt(cnt_a)
`endif
  );

  pc_sequencer #(.PC_W(4), .START_ADDR(14)) u_b (
    .clk(clk), .reset(reset), .req(req), .done(done_b),
    .fetch_en(fe_b), .prog_addr(addr_b), .branch(branch),
    .how_high(how_high), .take(take), .halt(halt), .stall(stall),
    .lut_we(lut_we), .lut_addr(lut_addr), .lut_data(lut_data[3:0])
`ifdef PC_SEQ_CYCLE_CNT_EN
    , .cycle_cnt(cnt_b)
`endif
  );

  typedef struct {
    longint pa;
    longint pb;
    longint dn;
    longint fe;
    longint cnt;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Behavioural model: run flags, PCs as plain integers modulo 2^W
  bit     m_running, m_finished;
  longint m_pc  [2];
  longint m_lut [2][4];
  longint m_cnt;
  int     wid   [2] = '{10, 4};
  int     st    [2] = '{0, 14};

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_step();
    exp_t e;
    if (reset) begin
      m_running  = 0;
      m_finished = 0;
      m_cnt      = 0;
      for (int k = 0; k < 2; k++) begin
        m_pc[k] = 0;
        for (int j = 0; j < 4; j++) m_lut[k][j] = 0;
      end
    end else if (!m_running && !m_finished) begin
      if (lut_we)
        for (int k = 0; k < 2; k++)
          m_lut[k][lut_addr] = longint'(lut_data) % (64'd1 << wid[k]);
      if (req) begin
        m_running = 1;
        m_cnt     = 0;
        for (int k = 0; k < 2; k++) m_pc[k] = st[k];
      end
    end else if (m_running) begin
      if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
      if (stall) begin
        m_running = 1;
      end else if (halt) begin
        m_running  = 0;
        m_finished = 1;
      end else if (branch && take) begin
        for (int k = 0; k < 2; k++) m_pc[k] = m_lut[k][how_high];
      end else begin
        for (int k = 0; k < 2; k++)
          m_pc[k] = (m_pc[k] + 1) % (64'd1 << wid[k]);
      end
    end else begin
      if (!req) m_finished = 0;
    end
    e.pa  = m_pc[0];
    e.pb  = m_pc[1];
    e.dn  = m_finished ? 1 : 0;
    e.fe  = m_running ? 1 : 0;
    e.cnt = m_cnt;
    q.push_back(e);
  endfunction

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("prog_addr_w10", longint'(addr_a), e.pa);
      chk("prog_addr_w4", longint'(addr_b), e.pb);
      chk("done", longint'(done_a), e.dn);
      chk("fetch_en", longint'(fe_a), e.fe);
      chk("done_w4", longint'(done_b), e.dn);
      chk("fetch_en_w4", longint'(fe_b), e.fe);
`ifdef PC_SEQ_CYCLE_CNT_EN
      chk("cycle_cnt", longint'(cnt_a), e.cnt);
      chk("cycle_cnt_w4", longint'(cnt_b), e.cnt);
`endif
    end
  end

  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  task automatic clr();
    req = 0; branch = 0; take = 0; halt = 0; stall = 0;
    lut_we = 0; how_high = 0; lut_addr = 0; lut_data = 0;
  endtask

  initial begin
    int g;
    reset = 1;
    clr();
    @(negedge clk);
    tick();
    tick();
    chk("reset_addr", longint'(addr_a), 0);
    chk("reset_done", longint'(done_a), 0);
    chk("reset_fetch", longint'(fe_a), 0);
    reset = 0;

    lut_we = 1; lut_addr = 2; lut_data = 10'h155; tick();
    lut_addr = 1; lut_data = 10'h0AA; tick();
    lut_addr = 3; lut_data = 10'h008; tick();
    clr();
    req = 1; tick();
    req = 0;
    chk("start_addr", longint'(addr_a), 0);
    chk("start_addr_w4", longint'(addr_b), 14);
    chk("start_fetch", longint'(fe_a), 1);

    g = 0;
    while (m_pc[0] != 5 && g < 50) begin tick(); g++; end
    chk("reach_pc5_bound", longint'(g < 50), 1);
    branch = 1; how_high = 2; take = 1; tick();
    chk("branch_taken", longint'(addr_a), 'h155);
    take = 0; tick();
    chk("branch_not_taken", longint'(addr_a), 'h156);
    clr();

    lut_we = 1; lut_addr = 1; lut_data = 10'h3FF; tick();
    clr();
    branch = 1; take = 1; how_high = 1; tick();
    chk("lut_we_ignored_run", longint'(addr_a), 'h0AA);
    how_high = 3; tick();
    clr();
    chk("at_pc8", longint'(addr_a), 8);
    stall = 1; halt = 1; tick(); tick();
    chk("stall_hold", longint'(addr_a), 8);
    stall = 0; tick();
    clr();
    chk("halt_done", longint'(done_a), 1);
    chk("halt_addr", longint'(addr_a), 8);
    req = 1; tick(); tick(); tick();
    chk("done_held", longint'(done_a), 1);
    req = 0; tick();
    chk("done_cleared", longint'(done_a), 0);

    req = 1; tick();
    req = 0; tick(); tick(); tick();
    reset = 1; tick();
    reset = 0;
    chk("midrun_reset_addr", longint'(addr_a), 0);
    chk("midrun_reset_fetch", longint'(fe_a), 0);
    req = 1; tick();
    req = 0; branch = 1; take = 1; how_high = 2; tick();
    clr();
    chk("lut_cleared", longint'(addr_a), 0);
    halt = 1; tick();
    clr(); tick();

    req = 1; tick();
    req = 0;
    repeat (6) tick();
    stall = 1; repeat (3) tick();
    stall = 0; halt = 1; tick();
    clr();
`ifdef PC_SEQ_CYCLE_CNT_EN
    chk("cnt_at_halt", longint'(cnt_a), 10);
    tick(); tick();
    chk("cnt_held_done", longint'(cnt_a), 10);
    req = 1; tick();
    chk("cnt_restart", longint'(cnt_a), 0);
`else
    tick(); tick();
    req = 1; tick();
`endif
    clr();

    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 199) == 0);
      req      = ($urandom_range(0, 3) == 0);
      branch   = ($urandom_range(0, 2) == 0);
      take     = $urandom_range(0, 1) != 0;
      halt     = ($urandom_range(0, 24) == 0);
      stall    = ($urandom_range(0, 3) == 0);
      lut_we   = ($urandom_range(0, 2) == 0);
      how_high = 2'($urandom_range(0, 3));
      lut_addr = 2'($urandom_range(0, 3));
      lut_data = 10'($urandom);
      tick();
    end
    reset = 0;
    clr();
    tick();
    @(posedge clk);
    #3;
    chk("scoreboard_drained", longint'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter and run-state sequencer for the single-cycle core; sits between the control decoder and instruction ROM.
- Owns the PC, the start/done handshake with the testbench, and the 4-entry branch target LUT indexed by the decoder's 2-bit how_high field.
- Applies branch, halt and stall decisions each cycle to produce the next fetch address.

Parameters:
- PC_W, 10, program counter / instruction ROM address width
- START_ADDR, 0, PC value loaded on every run start

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- req  input  1  run request from testbench
- done  output  1  program finished; high in DONE state
- fetch_en  output  1  instruction ROM read enable; high in RUN state
- prog_addr  output  PC_W  current PC, registered
- branch  input  1  decoder branch flag for the current instruction
- how_high  input  2  LUT index for the branch target
- take  input  1  ALU branch condition; branch taken only if branch&&take
- halt  input  1  decoder halt flag for the current instruction
- stall  input  1  hold PC this cycle (multi-cycle memory access)
- lut_we  input  1  target LUT write enable
- lut_addr  input  2  target LUT write index
- lut_data  input  PC_W  target LUT write data

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: state=IDLE, prog_addr=0, done=0, fetch_en=0, all 4 LUT entries=0. Reset mid-RUN aborts at the next edge with the same values; no instruction retires in that cycle.
- States: IDLE, RUN, DONE.
- IDLE:
  - done=0, fetch_en=0, prog_addr holds.
  - req=1 -> RUN next cycle, prog_addr<=START_ADDR.
- RUN:
  - fetch_en=1. Per edge, priority stall > halt > taken branch > increment.
  - stall=1: prog_addr holds, state holds; halt, branch and take are ignored.
  - halt=1: -> DONE, prog_addr holds.
  - branch&&take: prog_addr<=lut[how_high] (absolute target).
  - Otherwise prog_addr<=prog_addr+1, modulo 2^PC_W (all-ones wraps to 0, no flag).
  - req is ignored in RUN.
- DONE:
  - done=1, fetch_en=0, prog_addr holds the halt address.
  - req=0 -> IDLE next cycle (done falls with the state change).
  - req held high stays in DONE; there is no re-run without a req low pulse.
- LUT writes:
  - Accepted only in IDLE; lut_we is ignored in RUN and DONE.
  - Write takes effect at the edge.
  - lut_we and req together in IDLE: the write and the start both occur; the entry is valid for the first branch.
- Branch latency: the target is presented on prog_addr one cycle after the branch instruction's fetch cycle (no delay slot).
- Outputs are all registered or decoded from state; there are no combinational paths from branch, take or halt to outputs.

Optional Feature:
- Macro: PC_SEQ_CYCLE_CNT_EN
- Defined: adds output cycle_cnt (32 bits).
  - Cleared on reset and on IDLE->RUN.
  - Increments every clock cycle in RUN, including stall cycles.
  - Saturates at all-ones.
  - Holds in DONE and IDLE.
- Undefined: no port, no counter logic; all other behaviour identical.

Test Plan:
- Reset, then req=1 for 1 cycle with START_ADDR=0 -> RUN; prog_addr sequence 0,1,2,3 with fetch_en=1 and done=0.
- In IDLE write lut[2]=0x155; in RUN at PC=5 drive branch=1, how_high=2, take=1 -> next prog_addr=0x155; repeat with take=0 -> next prog_addr=6.
- At PC=8 drive stall=1 and halt=1 for 2 cycles, then halt only -> PC holds at 8 through the stall, then DONE with done=1 and prog_addr=8. Hold req=1 -> stays DONE; req=0 -> IDLE, done=0.
- PC_W=4, run from 14 with no branches -> prog_addr 14,15,0,1.
- lut_we=1 (addr 1, data 0x3FF) during RUN -> ignored; later taken branch with how_high=1 goes to the earlier IDLE-written value. Assert reset mid-RUN -> next cycle IDLE, prog_addr=0, LUT entries read back as 0 via branch.
- With PC_SEQ_CYCLE_CNT_EN: run 10 cycles including 3 stall cycles, then halt -> cycle_cnt=10, held in DONE; next start clears it to 0.
